// File: rtl/blink_pkg.sv
// Shared types and default timing for the blink-rate controller.
package blink_pkg;

  localparam int unsigned CLK_HZ_DEF         = 50_000_000;
  localparam int unsigned DEBOUNCE_DEF       = 1_000_000;
  localparam int unsigned LONG_PRESS_DEF     = 50_000_000;

  typedef logic [1:0] rate_t;

  typedef enum logic [1:0] {
    IDLE,
    PRESSED,
    HELD
  } press_state_e;

endpackage

// File: rtl/blink_rate_ctrl_if.sv
// Button input and tick/rate/run outputs of the blink-rate controller.
interface blink_rate_ctrl_if;
  import blink_pkg::*;

  logic  KEY;
  logic  tick;
  rate_t rate;
  logic  run;

  modport master (output KEY, input tick, rate, run);
  modport slave  (input KEY, output tick, rate, run);

endinterface

// File: rtl/key_debounce.sv
// Two-flop synchronizer on the raw button followed by a stability counter.
module key_debounce
  import blink_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_DEF
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic key_i,
  output logic key_db_o
);

  localparam int unsigned DW = $clog2(DEBOUNCE_CYCLES);

  logic [1:0]    sync_q;
  logic          key_db_q, key_db_d;
  logic [DW-1:0] db_cnt_q, db_cnt_d;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q   <= 2'b11;
      key_db_q <= 1'b1;
      db_cnt_q <= '0;
    end else begin
      sync_q   <= {sync_q[0], key_i};
      key_db_q <= key_db_d;
      db_cnt_q <= db_cnt_d;
    end
  end

  // Accept the synchronized level only after it has differed for the full window.
  always_comb begin
    key_db_d = key_db_q;
    db_cnt_d = db_cnt_q;
    if (sync_q[1] == key_db_q) begin
      db_cnt_d = '0;
    end else if (db_cnt_q == DW'(DEBOUNCE_CYCLES - 1)) begin
      key_db_d = sync_q[1];
      db_cnt_d = '0;
    end else begin
      db_cnt_d = db_cnt_q + DW'(1);
    end
  end

  assign key_db_o = key_db_q;

endmodule

// File: rtl/blink_rate_ctrl.sv
// Button-driven blink-rate selector: short press steps the rate, long press
// toggles run/pause, and a prescaler emits a one-cycle tick at the chosen rate.
module blink_rate_ctrl
  import blink_pkg::*;
#(
  parameter int unsigned CLK_HZ            = CLK_HZ_DEF,
  parameter int unsigned DEBOUNCE_CYCLES   = DEBOUNCE_DEF,
  parameter int unsigned LONG_PRESS_CYCLES = LONG_PRESS_DEF
) (
  input logic             CLOCK_50,
  input logic             RESET,
  blink_rate_ctrl_if.slave bus
);

  localparam int unsigned CW = $clog2(CLK_HZ);
  localparam int unsigned HW = $clog2(LONG_PRESS_CYCLES);

  logic          key_db;
  press_state_e  state_q, state_d;
  logic [HW-1:0] hold_q, hold_d;
  rate_t         rate_q, rate_d;
  logic          run_q, run_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          tick_q, tick_d;
  logic          evt_c;
  logic [CW-1:0] last_c;

  key_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_key_debounce (
    .clk_i   (CLOCK_50),
    .rst_i   (RESET),
    .key_i   (bus.KEY),
    .key_db_o(key_db)
  );

  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      state_q <= IDLE;
      hold_q  <= '0;
      rate_q  <= '0;
      run_q   <= 1'b1;
      cnt_q   <= '0;
      tick_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      rate_q  <= rate_d;
      run_q   <= run_d;
      cnt_q   <= cnt_d;
      tick_q  <= tick_d;
    end
  end

  // Press classifier; evt_c flags any rate or run change so the prescaler restarts.
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    rate_d  = rate_q;
    run_d   = run_q;
    evt_c   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!key_db) begin
          state_d = PRESSED;
          hold_d  = '0;
        end
      end
      PRESSED: begin
        if (key_db) begin
          rate_d  = rate_q + 2'd1;
          state_d = IDLE;
          evt_c   = 1'b1;
        end else begin
          hold_d = hold_q + HW'(1);
          if (hold_q == HW'(LONG_PRESS_CYCLES - 2)) begin
            run_d   = ~run_q;
            state_d = HELD;
            evt_c   = 1'b1;
          end
        end
      end
      HELD: begin
        if (key_db) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign last_c = CW'((CLK_HZ >> rate_q) - 1);

  // Prescaler; a control change in the same cycle wins over a due tick.
  always_comb begin
    cnt_d  = cnt_q;
    tick_d = 1'b0;
    if (evt_c || !run_q) begin
      cnt_d = '0;
    end else if (cnt_q == last_c) begin
      cnt_d  = '0;
      tick_d = 1'b1;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  assign bus.tick = tick_q;
  assign bus.rate = rate_q;
  assign bus.run  = run_q;

endmodule

// File: tb/tb_blink_rate_ctrl.sv
// Directed-plus-random bench for blink_rate_ctrl against an event-level model
// of press classification and tick timing.
module tb_blink_rate_ctrl;
  import blink_pkg::*;

  localparam int unsigned CLK_HZ = 16;
  localparam int unsigned DB     = 4;
  localparam int unsigned LP     = 20;

  typedef struct {
    int edge_n;
    bit is_run;
  } ev_t;

  logic clk;
  logic rst;

  int   cyc;
  int   r_m;
  int   rate_m;
  bit   run_m;
  ev_t  evq[$];
  int   checks;
  int   failures;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  blink_rate_ctrl_if bus ();

  blink_rate_ctrl #(
    .CLK_HZ           (CLK_HZ),
    .DEBOUNCE_CYCLES  (DB),
    .LONG_PRESS_CYCLES(LP)
  ) dut (
    .CLOCK_50(clk),
    .RESET   (rst),
    .bus     (bus)
  );

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s cyc=%0d observed=%0d expected=%0d", tag, cyc, obs, exp);
    end
  endtask

  // A press of L cycles starting after edge c: debounced edges land 2+DB later.
  task automatic schedule(input int c, input int len);
    int f;
    ev_t e;
    f = c + 2 + int'(DB);
    if (len >= int'(DB)) begin
      if (len < int'(LP)) begin
        e.edge_n = f + len + 1;
        e.is_run = 1'b0;
      end else begin
        e.edge_n = f + int'(LP);
        e.is_run = 1'b1;
      end
      evq.push_back(e);
    end
  endtask

  task automatic step();
    int   p;
    logic exp_tick;
    @(posedge clk);
    #1;
    cyc++;
    if (evq.size() > 0 && evq[0].edge_n == cyc) begin
      if (evq[0].is_run) run_m = !run_m;
      else               rate_m = (rate_m + 1) % 4;
      r_m = cyc;
      void'(evq.pop_front());
    end
    p        = int'(CLK_HZ) >> rate_m;
    exp_tick = run_m && (cyc != r_m) && (((cyc - r_m) % p) == 0);
    check("tick", {3'b0, bus.tick}, {3'b0, exp_tick});
    check("rate", {2'b0, bus.rate}, 4'(rate_m));
    check("run",  {3'b0, bus.run},  {3'b0, run_m});
  endtask

  task automatic press(input int len, input int gap);
    schedule(cyc, len);
    bus.KEY = 1'b0;
    repeat (len) step();
    bus.KEY = 1'b1;
    repeat (gap) step();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_tick"}, {3'b0, bus.tick}, 4'd0);
    check({tag, "_rate"}, {2'b0, bus.rate}, 4'd0);
    check({tag, "_run"},  {3'b0, bus.run},  4'd1);
  endtask

  // Wait until a short press of length len would complete exactly on a due tick.
  task automatic press_on_tick(input int len);
    bit aligned;
    int p;
    aligned = 1'b0;
    for (int i = 0; i < 64; i++) begin
      p = int'(CLK_HZ) >> rate_m;
      if (((cyc + 3 + int'(DB) + len - r_m) % p) == 0) begin
        aligned = 1'b1;
        break;
      end
      step();
    end
    checks++;
    assert (aligned) else begin
      failures++;
      $error("FAIL align cyc=%0d observed=0 expected=1", cyc);
    end
    press(len, 30);
  endtask

  initial begin
    int lr;
    checks   = 0;
    failures = 0;
    cyc      = 0;
    r_m      = 0;
    rate_m   = 0;
    run_m    = 1'b1;
    rst      = 1'b1;
    bus.KEY  = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("por");
    rst = 1'b0;

    // Free-running ticks at rate 0
    repeat (50) step();

    // Glitches shorter than the debounce window
    press(int'(DB) - 1, 20);
    press(1, 15);

    // Short presses walk the rate 1,2,3 and wrap to 0
    press(int'(DB), 25);
    press(int'(LP) - 1, 25);
    press(int'($urandom_range(DB, LP - 1)), 20 + int'($urandom_range(0, 20)));
    press(int'($urandom_range(DB, LP - 1)), 40);
    press(int'($urandom_range(DB, LP - 1)), 20 + int'($urandom_range(0, 20)));

    // Long presses pause then resume; boundary at exactly LP
    press(int'(LP), 40);
    press(int'($urandom_range(LP + 2, LP + 20)), 40);
    press(int'($urandom_range(LP + 2, LP + 20)), 40);
    press(int'($urandom_range(LP + 2, LP + 20)), 40);

    // Short-press completion landing on a due tick
    press_on_tick(int'($urandom_range(DB, LP - 1)));
    press_on_tick(int'($urandom_range(DB, LP - 1)));
    press_on_tick(int'($urandom_range(DB, LP - 1)));

    // Reset while a press is in progress, key still held afterwards
    if (rate_m == 0) press(int'(DB) + 2, 30);
    bus.KEY = 1'b0;
    repeat (int'(DB) + 8) step();
    #2;
    rst = 1'b1;
    #1;
    check_reset_outputs("async_rst");
    evq.delete();
    rate_m = 0;
    run_m  = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("hold_rst");
    rst = 1'b0;
    cyc = 0;
    r_m = 0;
    lr  = int'(LP) + 10 + int'($urandom_range(0, 10));
    schedule(0, lr);
    repeat (lr) step();
    bus.KEY = 1'b1;
    repeat (40) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
